fetch_prefetch_stage: RTL and testbench

// Parametrised instruction-fetch stage, successor to the single-register fetch stage.
// - Issues sequential PC requests to instruction memory over a valid/ready request channel and accepts in-order responses.
// - Buffers fetched words in a QDEPTH-entry prefetch queue and hands {pc, instr} to decode over a valid/ready handshake.
// - Supports redirect (taken branch/jump) by flushing and discarding stale in-flight responses.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_prefetch_stage_if.sv | 38 +++
 rtl/fetch_queue.sv | 64 ++++++
 rtl/fetch_prefetch_stage.sv | 128 ++++++++++++
 tb/tb_fetch_prefetch_stage.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch prefetch stage.
// Contents: fetch state enum, default-width {pc, instr} queue entry, default widths/step.
// No ports; imported by the interface, the queue and the top level.
package fetch_pkg;

  localparam int DEF_INSTR_W = 64;
  localparam int DEF_PC_W    = 16;
  localparam int DEF_PC_STEP = 4;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } fetch_state_e;

  // Entry at the default widths; parameterised instances build the same layout locally.
  typedef struct packed {
    logic [DEF_PC_W-1:0]    pc;
    logic [DEF_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_stage_if.sv
// Bundle of fetch control, memory request/response and decode handoff signals.
// master: the fetch stage (drives mem_req_*, inst_valid/pc/data).
// slave : the environment (drives control, mem_req_ready, mem_rsp_*, inst_ready).
interface fetch_prefetch_stage_if
  import fetch_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W
);

  logic               fetch_en;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;

  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [PC_W-1:0]    mem_req_addr;
  logic               mem_rsp_valid;
  logic [INSTR_W-1:0] mem_rsp_data;

  logic               inst_valid;
  logic               inst_ready;
  logic [PC_W-1:0]    inst_pc;
  logic [INSTR_W-1:0] inst_data;

  modport master (
    input  fetch_en, redirect, redirect_pc,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
    output mem_req_valid, mem_req_addr, inst_valid, inst_pc, inst_data
  );

  modport slave (
    output fetch_en, redirect, redirect_pc,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
    input  mem_req_valid, mem_req_addr, inst_valid, inst_pc, inst_data
  );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO with a registered head; push->head visible 1 cycle later.
// Ports: clk, rst (async low), push/push_dat, pop, flush, count, full, empty, head.
// Backpressure: push ignored when full unless popping the same cycle; pop ignored when empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  T              push_dat,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output T              head
);

  T              mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_nxt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_nxt  = rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_nxt;
      count <= count + CW'(do_push) - CW'(do_pop);
      // The head register mirrors mem[rd_ptr]: it takes the pushed word when that
      // word becomes the only entry, otherwise the next stored entry on a pop.
      if (do_push && (empty || (do_pop && count == CW'(1))))
        head <= push_dat;
      else if (do_pop && count > CW'(1))
        head <= mem[rd_nxt];
    end
  end

endmodule

// File: rtl/fetch_prefetch_stage.sv
// Sequential instruction fetch with QDEPTH-entry prefetch queue and redirect flush.
// Ports: clk, rst (async low), bus (master): fetch control, mem req/rsp, decode handoff.
// Latency: response to inst_valid 1 cycle; requests stop when in-flight + queued reaches QDEPTH.
module fetch_prefetch_stage
  import fetch_pkg::*;
#(
  parameter int INSTR_W  = DEF_INSTR_W,
  parameter int PC_W     = DEF_PC_W,
  parameter int PC_STEP  = DEF_PC_STEP,
  parameter int RESET_PC = 0,
  parameter int QDEPTH   = 4
) (
  input logic                   clk,
  input logic                   rst,
  fetch_prefetch_stage_if.master bus
);

  localparam int              CW         = $clog2(QDEPTH) + 1;
  localparam logic [PC_W-1:0] RESET_ADDR = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] STEP       = PC_W'(PC_STEP);
  localparam logic [CW:0]     CREDITS    = (CW+1)'(QDEPTH);

  // Same {pc, instr} layout as fetch_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  fetch_state_e    state;
  fetch_state_e    state_nxt;
  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   out_nxt;
  logic [CW:0]     credit_used;
  logic            req_valid;
  logic            req_fire;
  logic            redir;
  logic            rsp_keep;
  logic            rsp_drop;
  logic            q_full;
  logic            q_empty;
  entry_t          push_dat;
  entry_t          head;

  // Redirect is ignored during the boot cycle.
  assign redir       = bus.redirect && (state != S_BOOT);
  // Every in-flight request owns a queue slot, so responses never need a ready.
  assign credit_used = {1'b0, outstanding} + {1'b0, q_count};

  always_comb begin
    state_nxt = state;
    req_valid = 1'b0;
    case (state)
      S_BOOT: state_nxt = S_RUN;
      S_RUN: begin
        req_valid = !bus.redirect && (credit_used < CREDITS);
        if (!bus.fetch_en) state_nxt = S_HALT;
      end
      S_HALT: if (bus.fetch_en) state_nxt = S_RUN;
      default: state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_BOOT;
    else      state <= state_nxt;
  end

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = fetch_pc;
  assign req_fire          = req_valid && bus.mem_req_ready;
  assign rsp_drop          = bus.mem_rsp_valid && (drop_cnt != '0);
  assign rsp_keep          = bus.mem_rsp_valid && (drop_cnt == '0);
  assign out_nxt           = outstanding + CW'(req_fire) - CW'(bus.mem_rsp_valid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_ADDR;
      rsp_pc      <= RESET_ADDR;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= out_nxt;
      if (redir) begin
        fetch_pc <= bus.redirect_pc;
        rsp_pc   <= bus.redirect_pc;
        // Everything still in flight is stale, including words already marked for
        // dropping, so the new drop count is simply the remaining outstanding count.
        drop_cnt <= out_nxt;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + STEP;
        if (rsp_keep) rsp_pc   <= rsp_pc + STEP;
        if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  assign push_dat = '{pc: rsp_pc, instr: bus.mem_rsp_data};

  fetch_queue #(
    .DEPTH (QDEPTH),
    .T     (entry_t)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (rsp_keep && !redir),
    .push_dat (push_dat),
    .pop      (bus.inst_ready),
    .flush    (redir),
    .count    (q_count),
    .full     (q_full),
    .empty    (q_empty),
    .head     (head)
  );

  assign bus.inst_valid = !q_empty;
  assign bus.inst_pc    = head.pc;
  assign bus.inst_data  = head.instr;

  a_bounds: assert property (@(posedge clk) disable iff (!rst)
    (outstanding <= CW'(QDEPTH)) && (q_count <= CW'(QDEPTH)) &&
    (drop_cnt <= CW'(QDEPTH)) && (drop_cnt <= outstanding) &&
    !(q_full && rsp_keep && !bus.inst_ready));

endmodule

// File: tb/tb_fetch_prefetch_stage.sv
// Randomised and directed bench for fetch_prefetch_stage against a queue-based reference.
// Instances: 16-bit PC / 64-bit instr DUT (main) and 8-bit PC / 32-bit instr DUT (wrap test).
// The memory model answers in order with per-request latency; the model predicts every output.
module tb_fetch_prefetch_stage;

  localparam int QD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_prefetch_stage_if #(.PC_W(16), .INSTR_W(64)) bus ();
  fetch_prefetch_stage_if #(.PC_W(8),  .INSTR_W(32)) bus_b ();

  fetch_prefetch_stage #(
    .INSTR_W(64), .PC_W(16), .PC_STEP(4), .RESET_PC(0), .QDEPTH(QD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  fetch_prefetch_stage #(
    .INSTR_W(32), .PC_W(8), .PC_STEP(4), .RESET_PC(0), .QDEPTH(QD)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.master)
  );

  typedef struct {
    logic [15:0] addr;
    logic [63:0] data;
    int          due;
    bit          stale;
  } req_t;

  typedef struct {
    logic [15:0] pc;
    logic [63:0] data;
  } ent_t;

  req_t        inflight[$];
  ent_t        q[$];
  logic [15:0] m_pc;
  logic [15:0] seq_pc;
  int          cyc;
  int          gcyc;
  int          last_due;
  bit          prev_en;
  int          lat_min;
  int          lat_max;
  int          checks;
  int          errors;
  int          acc_addr[$];
  int          acc_cyc[$];
  int          del_pc[$];
  int          del_cyc[$];
  int          b_acc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int at(input int qq[$], input int i);
    if (i < qq.size()) return qq[i];
    return -1;
  endfunction

  // One clock cycle: drive memory response, compare outputs, advance the model.
  task automatic step();
    bit running;
    bit boot;
    bit exp_rv;
    bit fire;
    bit redir;
    bit rsp;
    int lat;
    rsp = (inflight.size() > 0) && (inflight[0].due <= gcyc);
    bus.mem_rsp_valid = rsp;
    bus.mem_rsp_data  = rsp ? inflight[0].data : 64'h0;
    boot    = (cyc == 0);
    running = (cyc == 1) || (cyc >= 2 && prev_en);
    exp_rv  = running && !bus.redirect && (inflight.size() + q.size() < QD);
    #1;
    check("req_valid", bus.mem_req_valid, exp_rv);
    check("req_addr", bus.mem_req_addr, m_pc);
    check("inst_valid", bus.inst_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("inst_pc", bus.inst_pc, q[0].pc);
      check("inst_data", bus.inst_data, q[0].data);
    end
    if (bus.mem_req_valid && bus.mem_req_ready) begin
      acc_addr.push_back(int'(bus.mem_req_addr));
      acc_cyc.push_back(gcyc);
    end
    if (bus.inst_valid && bus.inst_ready) begin
      del_pc.push_back(int'(bus.inst_pc));
      del_cyc.push_back(gcyc);
      check("seq_pc", bus.inst_pc, seq_pc);
      seq_pc = seq_pc + 16'd4;
    end
    if (bus_b.mem_req_valid && bus_b.mem_req_ready) b_acc.push_back(int'(bus_b.mem_req_addr));
    fire  = exp_rv && bus.mem_req_ready;
    redir = bus.redirect && !boot;
    @(posedge clk);
    if (q.size() > 0 && bus.inst_ready) void'(q.pop_front());
    if (rsp) begin
      req_t r;
      r = inflight.pop_front();
      if (!r.stale && !redir) q.push_back('{r.addr, r.data});
    end
    if (fire) begin
      req_t n;
      lat     = $urandom_range(lat_max, lat_min);
      n.addr  = m_pc;
      n.data  = {$urandom, $urandom};
      n.due   = (last_due + 1 > gcyc + lat) ? last_due + 1 : gcyc + lat;
      n.stale = 1'b0;
      last_due = n.due;
      inflight.push_back(n);
      m_pc = m_pc + 16'd4;
    end
    if (redir) begin
      q.delete();
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      m_pc   = bus.redirect_pc;
      seq_pc = bus.redirect_pc;
    end
    prev_en = bus.fetch_en;
    cyc++;
    gcyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_req_valid", bus.mem_req_valid, 1'b0);
    check("rst_req_addr", bus.mem_req_addr, 16'h0);
    check("rst_inst_valid", bus.inst_valid, 1'b0);
    check("rst_inst_pc", bus.inst_pc, 16'h0);
    check("rst_inst_data", bus.inst_data, 64'h0);
    bus.mem_rsp_valid = 1'b0;
    inflight.delete();
    q.delete();
    m_pc     = 16'h0;
    seq_pc   = 16'h0;
    cyc      = 0;
    last_due = 0;
    prev_en  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic clear_obs();
    acc_addr.delete();
    acc_cyc.delete();
    del_pc.delete();
    del_cyc.delete();
    b_acc.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_low;
    checks = 0;
    errors = 0;
    gcyc   = 0;
    bus.fetch_en        = 1'b1;
    bus.redirect        = 1'b0;
    bus.redirect_pc     = 16'h0;
    bus.mem_req_ready   = 1'b1;
    bus.mem_rsp_valid   = 1'b0;
    bus.mem_rsp_data    = 64'h0;
    bus.inst_ready      = 1'b1;
    bus_b.fetch_en      = 1'b0;
    bus_b.redirect      = 1'b0;
    bus_b.redirect_pc   = 8'h0;
    bus_b.mem_req_ready = 1'b0;
    bus_b.mem_rsp_valid = 1'b0;
    bus_b.mem_rsp_data  = 32'h0;
    bus_b.inst_ready    = 1'b1;
    #3;

    // 1: free-running fetch, latency 2
    lat_min = 2; lat_max = 2;
    do_reset();
    clear_obs();
    repeat (12) step();
    check("t1_addr0", at(acc_addr, 0), 0);
    check("t1_addr1", at(acc_addr, 1), 4);
    check("t1_addr2", at(acc_addr, 2), 8);
    check("t1_first_pc", at(del_pc, 0), 0);
    check("t1_latency", at(del_cyc, 0) - at(acc_cyc, 0), 3);

    // 2: decode stalled, credits run out at QDEPTH
    lat_min = 1; lat_max = 1;
    bus.inst_ready = 1'b0;
    do_reset();
    clear_obs();
    repeat (12) step();
    check("t2_n_acc", acc_addr.size(), 4);
    check("t2_req_valid_off", bus.mem_req_valid, 1'b0);
    check("t2_q_count", dut.q_count, 4);
    bus.inst_ready = 1'b1;
    repeat (10) step();
    check("t2_pop0", at(del_pc, 0), 0);
    check("t2_pop1", at(del_pc, 1), 4);
    check("t2_pop2", at(del_pc, 2), 8);
    check("t2_pop3", at(del_pc, 3), 12);
    check("t2_resume", at(acc_addr, 4), 16);

    // 3: redirect with 2 in flight and 1 queued
    lat_min = 3; lat_max = 3;
    bus.inst_ready = 1'b0;
    bus.mem_req_ready = 1'b1;
    do_reset();
    clear_obs();
    for (int n = 0; n < 20 && acc_addr.size() < 3; n++) step();
    bus.mem_req_ready = 1'b0;
    for (int n = 0; n < 10 && !(q.size() == 1 && inflight.size() == 2); n++) step();
    check("t3_outstanding", dut.outstanding, 2);
    check("t3_q_count", dut.q_count, 1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0100;
    step();
    bus.redirect = 1'b0;
    check("t3_valid_after_redir", bus.inst_valid, 1'b0);
    check("t3_drop_cnt", dut.drop_cnt, 1);
    clear_obs();
    bus.mem_req_ready = 1'b1;
    bus.inst_ready    = 1'b1;
    repeat (15) step();
    check("t3_first_pc", at(del_pc, 0), 16'h0100);
    check("t3_second_pc", at(del_pc, 1), 16'h0104);

    // 4: random ready/valid traffic, fetch_en pulses and redirects
    lat_min = 1; lat_max = 4;
    do_reset();
    clear_obs();
    en_low = 0;
    repeat (3000) begin
      bus.mem_req_ready = ($urandom_range(0, 3) != 0);
      bus.inst_ready    = ($urandom_range(0, 3) != 0);
      if (en_low > 0) en_low--;
      else if ($urandom_range(0, 29) == 0) en_low = $urandom_range(1, 6);
      bus.fetch_en    = (en_low == 0);
      bus.redirect    = (cyc >= 2) && ($urandom_range(0, 39) == 0);
      bus.redirect_pc = 16'($urandom) & 16'hFFFC;
      step();
    end
    bus.redirect = 1'b0;
    bus.fetch_en = 1'b1;
    check("t4_traffic", del_pc.size() > 200, 1'b1);

    // 5: 8-bit PC wrap on the second instance
    lat_min = 1; lat_max = 1;
    bus.mem_req_ready = 1'b1;
    bus.inst_ready    = 1'b1;
    do_reset();
    clear_obs();
    bus_b.fetch_en      = 1'b1;
    bus_b.mem_req_ready = 1'b0;
    repeat (2) step();
    bus_b.redirect    = 1'b1;
    bus_b.redirect_pc = 8'hF8;
    step();
    bus_b.redirect      = 1'b0;
    bus_b.mem_req_ready = 1'b1;
    repeat (8) step();
    bus_b.mem_req_ready = 1'b0;
    check("t5_n_acc", b_acc.size(), 4);
    check("t5_addr0", at(b_acc, 0), 8'hF8);
    check("t5_addr1", at(b_acc, 1), 8'hFC);
    check("t5_addr2", at(b_acc, 2), 8'h00);
    check("t5_addr3", at(b_acc, 3), 8'h04);

    // 6: reset with a full queue
    bus.inst_ready = 1'b0;
    do_reset();
    clear_obs();
    repeat (10) step();
    check("t6_full_before_rst", dut.q_count, 4);
    do_reset();
    clear_obs();
    bus.inst_ready = 1'b1;
    for (int n = 0; n < 10 && acc_addr.size() < 1; n++) step();
    check("t6_first_addr", at(acc_addr, 0), 0);
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
